wdt_core: RTL and testbench

//  Independent watchdog timer; consumer of the wdt_clk output of the clock block.

---
 rtl/wdt_core_if.sv | 39 +++
 rtl/wdt_core.sv | 159 +++++++++++++++
 tb/tb_wdt_core.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wdt_core_if.sv
// Key/config inputs and status outputs of the watchdog core.
// The window bound is carried only when WDT_WINDOW_EN is defined.
interface wdt_core_if #(
  parameter int CNT_W      = 12,
  parameter int PRESCALE_W = 3
);
  logic                  key_valid;
  logic [15:0]           key_data;
  logic [CNT_W-1:0]      reload;
  logic [PRESCALE_W-1:0] prescale;
`ifdef WDT_WINDOW_EN
  logic [CNT_W-1:0]      window;
`endif
  logic                  running;
  logic [CNT_W-1:0]      count;
  logic                  early_warn;
  logic                  wdt_reset;
  logic                  timeout_flag;

`ifdef WDT_WINDOW_EN
  modport master (
    output key_valid, key_data, reload, prescale, window,
    input  running, count, early_warn, wdt_reset, timeout_flag
  );
  modport slave (
    input  key_valid, key_data, reload, prescale, window,
    output running, count, early_warn, wdt_reset, timeout_flag
  );
`else
  modport master (
    output key_valid, key_data, reload, prescale,
    input  running, count, early_warn, wdt_reset, timeout_flag
  );
  modport slave (
    input  key_valid, key_data, reload, prescale,
    output running, count, early_warn, wdt_reset, timeout_flag
  );
`endif
endinterface

// File: rtl/wdt_core.sv
// Independent watchdog: synchronises wdt_clk, prescales its rising edges and counts down.
// Define WDT_WINDOW_EN to make a RELOAD key above the window bound fire (early kick).
module wdt_core #(
  parameter int          CNT_W      = 12,
  parameter int          PRESCALE_W = 3,
  parameter int          RST_PULSE  = 4,
  parameter logic [15:0] KEY_START  = 16'hCCCC,
  parameter logic [15:0] KEY_RELOAD = 16'hAAAA
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     wdt_clk,
  wdt_core_if.slave bus
);

  localparam int PRE_W   = (1 << PRESCALE_W) - 1;
  localparam int PULSE_W = $clog2(RST_PULSE + 1);

  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_TWO    = CNT_W'(2);
  localparam logic [PRE_W-1:0]   PRE_ONE    = PRE_W'(1);
  localparam logic [PULSE_W-1:0] PULSE_ONE  = PULSE_W'(1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIRE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic               early_warn_q, early_warn_d;
  logic               wdt_reset_q, wdt_reset_d;
  logic               timeout_flag_q, timeout_flag_d;

  logic               tick;
  logic [PRE_W-1:0]   pre_last;
  logic               pre_hit;
  logic               key_start;
  logic               key_reload;
  logic               key_bad;
  logic               early_kick;
  logic               fire;
  logic [CNT_W-1:0]   reload_val;

  // A zero reload would expire instantly, so it selects the longest timeout instead.
  function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] r);
    return (r == '0) ? '1 : r;
  endfunction

  assign tick       = sync_q[1] & ~sync_q[2];
  assign pre_last   = ~({PRE_W{1'b1}} << bus.prescale);
  assign pre_hit    = (pre_cnt_q == pre_last);
  assign key_start  = bus.key_valid && (bus.key_data == KEY_START);
  assign key_reload = bus.key_valid && (bus.key_data == KEY_RELOAD);
  assign key_bad    = bus.key_valid && !key_start && !key_reload;
  assign reload_val = load_value(bus.reload);

`ifdef WDT_WINDOW_EN
  assign early_kick = key_reload && (count_q > bus.window);
`else
  assign early_kick = 1'b0;
`endif

  always_comb begin
    sync_d         = {sync_q[1:0], wdt_clk};
    state_d        = state_q;
    pre_cnt_d      = pre_cnt_q;
    count_d        = count_q;
    pulse_cnt_d    = pulse_cnt_q;
    early_warn_d   = 1'b0;
    wdt_reset_d    = wdt_reset_q;
    timeout_flag_d = timeout_flag_q;
    fire           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (key_start) begin
          count_d   = reload_val;
          pre_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // A kick outranks a coincident decrement, so a timely kick never fires.
        if (key_bad || early_kick) begin
          fire = 1'b1;
        end else if (key_reload) begin
          count_d   = reload_val;
          pre_cnt_d = '0;
        end else if (tick) begin
          if (pre_hit) begin
            pre_cnt_d = '0;
            if (count_q == CNT_ONE) begin
              count_d = '0;
              fire    = 1'b1;
            end else begin
              count_d      = count_q - CNT_ONE;
              early_warn_d = (count_q == CNT_TWO);
            end
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_ONE;
          end
        end
      end
      ST_FIRE: begin
        if (pulse_cnt_q == '0) begin
          wdt_reset_d = 1'b0;
          count_d     = reload_val;
          pre_cnt_d   = '0;
          state_d     = ST_RUN;
        end else begin
          pulse_cnt_d = pulse_cnt_q - PULSE_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fire) begin
      state_d        = ST_FIRE;
      wdt_reset_d    = 1'b1;
      pulse_cnt_d    = PULSE_LAST;
      timeout_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sync_q         <= '0;
      pre_cnt_q      <= '0;
      count_q        <= '0;
      pulse_cnt_q    <= '0;
      early_warn_q   <= 1'b0;
      wdt_reset_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      pre_cnt_q      <= pre_cnt_d;
      count_q        <= count_d;
      pulse_cnt_q    <= pulse_cnt_d;
      early_warn_q   <= early_warn_d;
      wdt_reset_q    <= wdt_reset_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign bus.running      = (state_q != ST_IDLE);
  assign bus.count        = count_q;
  assign bus.early_warn   = early_warn_q;
  assign bus.wdt_reset    = wdt_reset_q;
  assign bus.timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_wdt_core.sv
// Scoreboarded bench for wdt_core: a per-cycle reference model queues expected outputs,
// a monitor pops and compares them; directed scenarios add direct output checks.
module tb_wdt_core;

  localparam int          CNT_W      = 12;
  localparam int          PRESCALE_W = 3;
  localparam int          RST_PULSE  = 4;
  localparam logic [15:0] KEY_START  = 16'hCCCC;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
  localparam int          PRE_MOD    = 2 ** ((2 ** PRESCALE_W) - 1);

  typedef struct packed {
    logic             running;
    logic [CNT_W-1:0] count;
    logic             early_warn;
    logic             wdt_reset;
    logic             timeout_flag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic wdt_clk;

  wdt_core_if #(.CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W)) bus ();

  wdt_core #(
    .CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W), .RST_PULSE(RST_PULSE),
    .KEY_START(KEY_START), .KEY_RELOAD(KEY_RELOAD)
  ) dut (
    .clk(clk), .reset(reset), .wdt_clk(wdt_clk), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // stimulus configuration, copied onto the bus at each drive point
  int cfg_reload = 5, cfg_prescale = 0, cfg_window = 0;
  int w_hi = 5, w_lo = 5, w_phase = 0, rises = 0;
  bit w_prev = 1'b0;

  // reference model: started/firing/count/ticks-toward-next-decrement
  bit m_started, m_flag, m_warn;
  int m_fire_left, m_count, m_pre;
  bit h_a, h_b, h_c;   // wdt_clk as sampled 1, 2 and 3 edges ago

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst_i, input bit kv, input logic [15:0] kd, input bit w);
    int  reload_eff;
    bit  tick, kick, bad, fire;
    reload_eff = (cfg_reload == 0) ? (2 ** CNT_W) - 1 : cfg_reload;
    tick = h_b && !h_c;
    h_c = h_b; h_b = h_a; h_a = w;
    m_warn = 1'b0;
    fire = 1'b0;
    if (rst_i) begin
      m_started = 0; m_fire_left = 0; m_count = 0; m_pre = 0; m_flag = 0;
      h_a = 0; h_b = 0; h_c = 0;
    end else if (m_fire_left > 0) begin
      m_fire_left--;
      if (m_fire_left == 0) begin
        m_count = reload_eff;
        m_pre = 0;
      end
    end else if (!m_started) begin
      if (kv && kd == KEY_START) begin
        m_started = 1; m_count = reload_eff; m_pre = 0;
      end
    end else begin
      kick = kv && (kd == KEY_RELOAD);
      bad  = kv && (kd != KEY_RELOAD) && (kd != KEY_START);
`ifdef WDT_WINDOW_EN
      if (kick && m_count > cfg_window) begin
        kick = 0;
        bad  = 1;
      end
`endif
      if (bad) fire = 1;
      else if (kick) begin
        m_count = reload_eff;
        m_pre = 0;
      end else if (tick) begin
        if (m_pre == (2 ** cfg_prescale) - 1) begin
          m_pre = 0;
          if (m_count == 1) begin
            m_count = 0;
            fire = 1;
          end else begin
            m_count--;
            m_warn = (m_count == 1);
          end
        end else m_pre = (m_pre + 1) % PRE_MOD;
      end
    end
    if (fire) begin
      m_fire_left = RST_PULSE;
      m_flag = 1;
    end
  endtask

  // one clock cycle of stimulus: drive at negedge, predict the next posedge
  task automatic cycle(input bit rst_i, input bit kv, input logic [15:0] kd);
    exp_t e;
    @(negedge clk);
    if (w_phase >= w_hi + w_lo - 1) w_phase = 0;
    else w_phase++;
    wdt_clk = (w_phase < w_hi);
    if (wdt_clk && !w_prev) rises++;
    w_prev = wdt_clk;
    reset = rst_i;
    bus.key_valid = kv;
    bus.key_data = kd;
    bus.reload = CNT_W'(cfg_reload);
    bus.prescale = PRESCALE_W'(cfg_prescale);
`ifdef WDT_WINDOW_EN
    bus.window = CNT_W'(cfg_window);
`endif
    model_step(rst_i, kv, kd, wdt_clk);
    e.running = m_started;
    e.count = CNT_W'(m_count);
    e.early_warn = m_warn;
    e.wdt_reset = (m_fire_left > 0);
    e.timeout_flag = m_flag;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0);
    w_phase = w_hi - 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0);
  endtask

  task automatic measure_pulse(output int n);
    n = 0;
    while (bus.wdt_reset === 1'b1 && n < 20) begin
      n++;
      cycle(1'b0, 1'b0, 16'h0);
    end
  endtask

  task automatic wait_count(input int target, input string name);
    int i;
    for (i = 0; i < 400 && bus.count !== CNT_W'(target); i++) idle(1);
    chk(name, (i < 400), 1);
  endtask

  // monitor: every expected entry is checked one time unit after its edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("running", bus.running, e.running);
        chk("count", bus.count, e.count);
        chk("early_warn", bus.early_warn, e.early_warn);
        chk("wdt_reset", bus.wdt_reset, e.wdt_reset);
        chk("timeout_flag", bus.timeout_flag, e.timeout_flag);
      end
    end
  end

  initial begin
    int seq[$];
    int last, warn_at, warns, n, min_cnt, saw_rst, found;
    bit got;

    // 1: plain expiry from reload 5
    do_reset(3);
    chk("rst_running", bus.running, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_wdt_reset", bus.wdt_reset, 0);
    chk("rst_flag", bus.timeout_flag, 0);
    cfg_reload = 5; cfg_prescale = 0; w_hi = 5; w_lo = 5;
    cycle(1'b0, 1'b1, KEY_START);
    last = -1; warn_at = -1; warns = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      idle(1);
      if (int'(bus.count) != last) begin
        seq.push_back(int'(bus.count));
        last = int'(bus.count);
      end
      if (bus.early_warn) begin
        warns++;
        warn_at = int'(bus.count);
      end
      if (bus.wdt_reset) got = 1;
    end
    chk("t1_fired", got, 1);
    chk("t1_seq_len", seq.size(), 6);
    for (int i = 0; i < seq.size() && i < 6; i++) chk("t1_seq", seq[i], 5 - i);
    chk("t1_warn_count", warns, 1);
    chk("t1_warn_at", warn_at, 1);
    measure_pulse(n);
    chk("t1_pulse_len", n, RST_PULSE);
    chk("t1_flag", bus.timeout_flag, 1);
    chk("t1_reload", bus.count, 5);
    chk("t1_running", bus.running, 1);

    // 2: regular kicks every 3 ticks keep it alive
    do_reset(2);
    cycle(1'b0, 1'b1, KEY_START);
    min_cnt = 5; saw_rst = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, (i % 30 == 29), KEY_RELOAD);
      if (bus.wdt_reset !== 1'b0) saw_rst = 1;
      if (int'(bus.count) < min_cnt) min_cnt = int'(bus.count);
    end
    chk("t2_no_reset", saw_rst, 0);
    chk("t2_min_ge2", (min_cnt >= 2), 1);

    // 3: bad key fires on the next cycle
    cycle(1'b0, 1'b1, 16'h1234);
    idle(1);
    chk("t3_fire_next", bus.wdt_reset, 1);
    measure_pulse(n);
    chk("t3_pulse_len", n, RST_PULSE);
    chk("t3_flag", bus.timeout_flag, 1);

    // 6: reset in the second FIRE cycle drops everything
    cycle(1'b0, 1'b1, 16'h5555);
    idle(1);
    cycle(1'b1, 1'b0, 16'h0);
    idle(1);
    chk("t6_wdt_reset", bus.wdt_reset, 0);
    chk("t6_running", bus.running, 0);
    chk("t6_flag", bus.timeout_flag, 0);
    idle(40);
    chk("t6_idle_count", bus.count, 0);
    chk("t6_idle_running", bus.running, 0);

    // 4: prescale 2, reload 3 -> fire after 12 rises
    do_reset(2);
    cfg_prescale = 2; cfg_reload = 3;
    rises = 0;
    cycle(1'b0, 1'b1, KEY_START);
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      idle(1);
      if (bus.wdt_reset) got = 1;
    end
    chk("t4_fired", got, 1);
    chk("t4_rises", rises, 12);
    idle(8);

    // 5: kick lands on the same edge as the final decrement
    cfg_prescale = 0; cfg_reload = 5;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_started && m_fire_left == 0 && m_count == 1 && h_b && !h_c && m_pre == 0) begin
        cycle(1'b0, 1'b1, KEY_RELOAD);
        found = 1;
      end else idle(1);
    end
    chk("t5_found", found, 1);
    idle(1);
    chk("t5_count", bus.count, 5);
    chk("t5_no_reset", bus.wdt_reset, 0);

`ifdef WDT_WINDOW_EN
    // 7: early kick above the window fires, kick inside it reloads
    do_reset(2);
    cfg_window = 2; cfg_reload = 5; cfg_prescale = 0;
    cycle(1'b0, 1'b1, KEY_START);
    wait_count(4, "t7_reach4");
    cycle(1'b0, 1'b1, KEY_RELOAD);
    idle(1);
    chk("t7_early_fire", bus.wdt_reset, 1);
    measure_pulse(n);
    wait_count(2, "t7_reach2");
    cycle(1'b0, 1'b1, KEY_RELOAD);
    idle(1);
    chk("t7_in_window", bus.count, 5);
    chk("t7_no_reset", bus.wdt_reset, 0);
`endif

    // random traffic against the model
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] kd;
      int r;
      if (i % 400 == 0) begin
        cfg_prescale = $urandom_range(0, 2);
        cfg_reload = $urandom_range(0, 7);
        cfg_window = $urandom_range(0, 7);
        w_hi = $urandom_range(3, 6);
        w_lo = $urandom_range(2, 6);
      end
      r = $urandom_range(0, 99);
      kd = (r < 70) ? KEY_RELOAD : (r < 85) ? KEY_START : 16'($urandom);
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) == 0), kd);
    end

    idle(2);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
